// File: rtl/bus_resp_if.sv
// bus_resp_if: CPU-side request/response plus RAM and I/O downstream ports of bus_resp.
interface bus_resp_if #(parameter int RAM_AW = 18);
  logic cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic [1:0] cpu_wstrb;
  logic mem_req, mem_we, mem_ack;
  logic [RAM_AW-2:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0] mem_wstrb;
  logic io_req, io_we, io_ack;
  logic [14:0] io_addr;
  logic [15:0] io_wdata, io_rdata;
  logic [1:0] io_wstrb;
  logic busy;
  modport slave (
    input cpu_req, cpu_addr, cpu_wdata, cpu_wstrb, cpu_we, mem_ack, mem_rdata, io_ack, io_rdata,
    output cpu_ack, cpu_rdata, cpu_err, mem_req, mem_addr, mem_wdata, mem_wstrb, mem_we,
    output io_req, io_addr, io_wdata, io_wstrb, io_we, busy
  );
  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_wstrb, cpu_we, mem_ack, mem_rdata, io_ack, io_rdata,
    input cpu_ack, cpu_rdata, cpu_err, mem_req, mem_addr, mem_wdata, mem_wstrb, mem_we,
    input io_req, io_addr, io_wdata, io_wstrb, io_we, busy
  );
endinterface

// File: rtl/bus_resp.sv
// bus_resp: CPU bus responder decoding RAM / I/O / unmapped space with one ack per request.
// Optional downstream request timeout enabled by defining BUS_TIMEOUT_EN.
module bus_resp #(
  parameter int RAM_AW = 18,
  parameter logic [7:0] IO_BASE = 8'hFF,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rstn,
  bus_resp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM, IO, RESP} state_t;
  state_t state, state_d;
  logic ack_q, err_q, mreq_q, ireq_q, busy_q, we_q;
  logic ack_d, err_d, mreq_d, ireq_d;
  logic [15:0] rdata_q, rdata_d, wdata_q, dn_rdata;
  logic [1:0] wstrb_q;
  logic [RAM_AW-2:0] maddr_q;
  logic [14:0] iaddr_q;
  logic is_ram, is_io, take, dn_ack, expire;
  // RAM decode takes priority so the windows can never both hit
  assign is_ram = bus.cpu_addr[23:RAM_AW] == '0;
  assign is_io = !is_ram && bus.cpu_addr[23:16] == IO_BASE;
  assign take = state == IDLE && bus.cpu_req;
  assign dn_ack = (state == MEM && bus.mem_ack) || (state == IO && bus.io_ack);
  assign dn_rdata = state == MEM ? bus.mem_rdata : bus.io_rdata;
`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else cnt <= (state == MEM || state == IO) ? cnt + 1'b1 : '0;
  assign expire = cnt == CW'(TIMEOUT - 1);
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state;
    ack_d = 1'b0;
    err_d = 1'b0;
    rdata_d = rdata_q;
    mreq_d = 1'b0;
    ireq_d = 1'b0;
    case (state)
      IDLE: if (bus.cpu_req) begin
        state_d = is_ram ? MEM : is_io ? IO : RESP;
        mreq_d = is_ram;
        ireq_d = is_io;
        ack_d = !is_ram && !is_io;
        err_d = ack_d;
        rdata_d = ack_d ? 16'hFFFF : rdata_q;
      end
      MEM, IO: begin
        ack_d = dn_ack || expire;
        err_d = !dn_ack && expire;
        state_d = ack_d ? RESP : state;
        rdata_d = err_d ? 16'hFFFF : (dn_ack && !we_q) ? dn_rdata : rdata_q;
        mreq_d = state == MEM && !ack_d;
        ireq_d = state == IO && !ack_d;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      mreq_q <= 1'b0;
      ireq_q <= 1'b0;
      busy_q <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q <= 1'b0;
      maddr_q <= '0;
      iaddr_q <= '0;
    end else begin
      state <= state_d;
      ack_q <= ack_d;
      err_q <= err_d;
      mreq_q <= mreq_d;
      ireq_q <= ireq_d;
      busy_q <= state_d != IDLE;
      rdata_q <= rdata_d;
      if (take) begin
        wdata_q <= bus.cpu_wdata;
        wstrb_q <= bus.cpu_wstrb;
        we_q <= bus.cpu_we;
        maddr_q <= bus.cpu_addr[RAM_AW-1:1];
        iaddr_q <= bus.cpu_addr[15:1];
      end
    end
  assign bus.cpu_ack = ack_q;
  assign bus.cpu_err = err_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_req = mreq_q;
  assign bus.mem_addr = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_we = we_q;
  assign bus.io_req = ireq_q;
  assign bus.io_addr = iaddr_q;
  assign bus.io_wdata = wdata_q;
  assign bus.io_wstrb = wstrb_q;
  assign bus.io_we = we_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_bus_resp.sv
// tb_bus_resp: directed table, corner sequences and randomized traffic checked against a transaction model.
module tb_bus_resp;
  localparam int RAM_AW = 18;
  localparam logic [7:0] IO_BASE = 8'hFF;
  localparam int TMO = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  bus_resp_if #(.RAM_AW(RAM_AW)) b ();
  bus_resp #(.RAM_AW(RAM_AW), .IO_BASE(IO_BASE), .TIMEOUT(TMO)) dut (.clk(clk), .rstn(rstn), .bus(b));
  int checks = 0, failures = 0;
  int o_acks, o_ackc, o_kind, o_daddr, o_stray, o_unstable, o_reqc;
  logic o_err, o_we;
  logic [15:0] o_rdata, o_wd;
  logic [1:0] o_ws;
  logic [15:0] prev = 16'h0000;
  typedef struct {
    logic [23:0] a; logic [15:0] wd; logic [1:0] ws; logic we; int d; logic [15:0] rd;
    int kind; int daddr; int ackc; logic err; logic [15:0] rdata;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic xact(input logic [23:0] a, input logic [15:0] wd, input logic [1:0] ws,
                      input logic we, input int d, input logic [15:0] rd, input bit extra);
    int reqc = 0;
    o_acks = 0; o_ackc = 0; o_kind = 0; o_daddr = 0; o_stray = 0; o_unstable = 0;
    o_err = 1'b0; o_we = 1'b0; o_rdata = '0; o_wd = '0; o_ws = '0;
    @(negedge clk);
    b.cpu_addr = a; b.cpu_wdata = wd; b.cpu_wstrb = ws; b.cpu_we = we; b.cpu_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      b.cpu_req = extra && c == 1;
      b.mem_ack = 1'b0; b.io_ack = 1'b0;
      b.mem_rdata = 16'($urandom); b.io_rdata = 16'($urandom);
      if (b.mem_req || b.io_req) begin
        reqc++;
        if (reqc == 1) begin
          o_kind = b.mem_req ? 1 : 2;
          o_daddr = b.mem_req ? int'(b.mem_addr) : int'(b.io_addr);
          o_wd = b.mem_req ? b.mem_wdata : b.io_wdata;
          o_ws = b.mem_req ? b.mem_wstrb : b.io_wstrb;
          o_we = b.mem_req ? b.mem_we : b.io_we;
        end else if (o_daddr != (b.mem_req ? int'(b.mem_addr) : int'(b.io_addr)) ||
                     o_wd != (b.mem_req ? b.mem_wdata : b.io_wdata)) o_unstable++;
        if (reqc == d + 1) begin
          if (b.mem_req) begin b.mem_ack = 1'b1; b.mem_rdata = rd; end
          else begin b.io_ack = 1'b1; b.io_rdata = rd; end
        end
      end
      if (b.cpu_err && !b.cpu_ack) o_stray++;
      if (b.cpu_ack) begin
        o_acks++;
        if (o_acks == 1) begin o_ackc = c; o_err = b.cpu_err; o_rdata = b.cpu_rdata; end
      end
      if (o_acks > 0 && c >= o_ackc + 2) break;
    end
    o_reqc = reqc;
  endtask

  task automatic verify(input string nm, input logic [15:0] wd, input logic [1:0] ws, input logic we,
                        input int kind, input int daddr, input int ackc, input logic err, input logic [15:0] rdata);
    chk({nm, ".acks"}, o_acks, 1);
    chk({nm, ".ack_cycle"}, o_ackc, ackc);
    chk({nm, ".err"}, o_err, err);
    chk({nm, ".rdata"}, o_rdata, rdata);
    chk({nm, ".port"}, o_kind, kind);
    chk({nm, ".stray_err"}, o_stray, 0);
    if (kind != 0) begin
      chk({nm, ".daddr"}, o_daddr, daddr);
      chk({nm, ".req_cycles"}, o_reqc, ackc - 1);
      chk({nm, ".fields"}, {o_we, o_ws, o_wd}, {we, ws, wd});
      chk({nm, ".stable"}, o_unstable, 0);
    end
    prev = rdata;
  endtask

  task automatic model_run(input string nm, input logic [23:0] a, input logic [15:0] wd, input logic [1:0] ws,
                           input logic we, input int d, input logic [15:0] rd);
    int kind, daddr, ackc;
    logic err;
    logic [15:0] er;
    kind = a < 24'(1 << RAM_AW) ? 1 : a[23:16] == IO_BASE ? 2 : 0;
    daddr = kind == 1 ? int'(a) >> 1 : int'(a[15:0]) >> 1;
    if (kind == 0) begin ackc = 1; err = 1'b1; er = 16'hFFFF; end
    else if (TO_EN && d >= TMO) begin ackc = TMO + 1; err = 1'b1; er = 16'hFFFF; end
    else begin ackc = d + 2; err = 1'b0; er = we ? prev : rd; end
    xact(a, wd, ws, we, d, rd, 1'b0);
    verify(nm, wd, ws, we, kind, daddr, ackc, err, er);
  endtask

  initial begin
    b.cpu_req = 0; b.cpu_addr = 0; b.cpu_wdata = 0; b.cpu_wstrb = 0; b.cpu_we = 0;
    b.mem_ack = 0; b.mem_rdata = 0; b.io_ack = 0; b.io_rdata = 0;
    tbl[0] = '{24'h000100, 16'h0000, 2'b11, 1'b0, 3, 16'h1234, 1, 'h80, 5, 1'b0, 16'h1234};
    tbl[1] = '{24'hFF0010, 16'hBEEF, 2'b10, 1'b1, 0, 16'h0000, 2, 8, 2, 1'b0, 16'h1234};
    tbl[2] = '{24'h800000, 16'h0000, 2'b11, 1'b0, 0, 16'h0000, 0, 0, 1, 1'b1, 16'hFFFF};
    tbl[3] = '{24'h03FFFE, 16'h5A5A, 2'b11, 1'b1, 1, 16'h0000, 1, 'h1FFFF, 3, 1'b0, 16'hFFFF};
    tbl[4] = '{24'h040000, 16'h0000, 2'b11, 1'b0, 0, 16'h0000, 0, 0, 1, 1'b1, 16'hFFFF};
    tbl[5] = '{24'hFFFFFE, 16'h0000, 2'b01, 1'b0, 2, 16'hCAFE, 2, 'h7FFF, 4, 1'b0, 16'hCAFE};
    tbl[6] = '{24'hFEFFFE, 16'h0000, 2'b11, 1'b0, 0, 16'h0000, 0, 0, 1, 1'b1, 16'hFFFF};
    tbl[7] = '{24'h000000, 16'h0000, 2'b11, 1'b0, 0, 16'h0001, 1, 0, 2, 1'b0, 16'h0001};
    tbl[8] = '{24'h123456, 16'h7777, 2'b11, 1'b1, 0, 16'h0000, 0, 0, 1, 1'b1, 16'hFFFF};
    repeat (2) @(negedge clk);
    chk("reset.ctrl", {b.cpu_ack, b.cpu_err, b.mem_req, b.io_req, b.busy, b.mem_we, b.io_we}, 0);
    chk("reset.rdata", b.cpu_rdata, 0);
    chk("reset.addr", {b.mem_addr, b.io_addr, b.mem_wstrb, b.io_wstrb}, 0);
    chk("reset.wdata", {b.mem_wdata, b.io_wdata}, 0);
    rstn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      xact(tbl[i].a, tbl[i].wd, tbl[i].ws, tbl[i].we, tbl[i].d, tbl[i].rd, 1'b0);
      verify($sformatf("vec%0d", i), tbl[i].wd, tbl[i].ws, tbl[i].we, tbl[i].kind, tbl[i].daddr,
             tbl[i].ackc, tbl[i].err, tbl[i].rdata);
    end
    xact(24'h000200, 16'h0000, 2'b11, 1'b0, 2, 16'h4321, 1'b1);
    verify("busy_req", 16'h0000, 2'b11, 1'b0, 1, 'h100, 4, 1'b0, 16'h4321);
    @(negedge clk);
    b.cpu_addr = 24'hFF0002; b.cpu_we = 1'b0; b.cpu_req = 1'b1;
    @(negedge clk);
    b.cpu_req = 1'b0;
    chk("midrst.io_req_before", b.io_req, 1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk("midrst.async_drop", {b.io_req, b.busy, b.cpu_ack}, 0);
    chk("midrst.rdata", b.cpu_rdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    prev = 16'h0000;
    xact(24'h000020, 16'h0000, 2'b11, 1'b0, 1, 16'h7777, 1'b0);
    verify("after_rst", 16'h0000, 2'b11, 1'b0, 1, 'h10, 3, 1'b0, 16'h7777);
`ifdef BUS_TIMEOUT_EN
    xact(24'h000100, 16'h0000, 2'b11, 1'b0, 1000, 16'h0000, 1'b0);
    verify("timeout", 16'h0000, 2'b11, 1'b0, 1, 'h80, TMO + 1, 1'b1, 16'hFFFF);
    xact(24'h000100, 16'h0000, 2'b11, 1'b0, TMO - 1, 16'h2468, 1'b0);
    verify("ack_at_expiry", 16'h0000, 2'b11, 1'b0, 1, 'h80, TMO + 1, 1'b0, 16'h2468);
`endif
    for (int i = 0; i < 150; i++) begin
      logic [23:0] a;
      int sel;
      sel = $urandom_range(0, 2);
      a = sel == 0 ? 24'($urandom_range(0, (1 << RAM_AW) - 1)) :
          sel == 1 ? {IO_BASE, 16'($urandom)} : 24'($urandom);
      model_run($sformatf("rnd%0d", i), a, 16'($urandom), 2'($urandom), 1'($urandom),
                $urandom_range(0, 6), 16'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
